rv_inst_encoder: RTL and testbench
==================================

Name: rv_inst_encoder

Overview:
RISC-V RV64 instruction encoder and instruction-memory writer. It accepts one decoded instruction per handshake: a one-hot instruction type, register indices and an immediate. It packs these into a 32-bit machine word and writes the word to sequential instruction-memory word addresses. It is the producing end of the fetch/decode path and is used to load program images that the fetch/decode logic reads back.

Parameters:
START_ADDR, 30'd0, first word address written after reset (address bits [31:2])
DEPTH, 1024, maximum number of words written before the block reports full; legal range 1..65535

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
instruction_type  input  23  one-hot opcode select, bits 22..0: jal, jalr, beq, bne, ld, sd, addi, slti, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, xor, srl, sra, or, and
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  32  signed immediate; byte offset for branch/jal; shift amount for slli/srli/srai
mem_addr_O  output  30  word address (bits [31:2]) of the pending write
mem_wdata_O  output  32  encoded instruction
mem_wen_O  output  1  write request; held until acknowledged
mem_ack_I  input  1  memory accepts the write this cycle
err_o  output  1  one-cycle pulse: the last accepted request was rejected
err_code  output  2  0 none, 1 type not one-hot, 2 immediate out of range; held until next accept
word_count  output  16  number of words written since reset
full_o  output  1  high once word_count == DEPTH

Behaviour:
- One clock. Reset is synchronous and active-low: when rst_n is low at a rising clk edge, all registers reset.
- Reset values: state=IDLE, mem_addr_O=START_ADDR, mem_wdata_O=0, mem_wen_O=0, err_o=0, err_code=0, word_count=0, full_o=0 (DEPTH≥1).
- Handshake: a request is accepted when in_valid && in_ready. in_ready = (state==IDLE) && !full_o.
- States:
  - IDLE → WRITE on an accepted, legal request. On that edge, mem_wdata_O is registered and mem_wen_O=1, so latency from accept to write request is 1 cycle.
  - IDLE → IDLE on an accepted, illegal request. err_o pulses for 1 cycle and err_code is set. There is no write, and the address and count are unchanged.
  - WRITE: mem_wen_O, mem_addr_O and mem_wdata_O are held stable until mem_ack_I. On the ack edge: mem_wen_O=0, mem_addr_O+=1 (30-bit wrap), word_count+=1. Next state is FULL if the new count equals DEPTH, otherwise IDLE.
  - FULL: terminal. in_ready=0, full_o=1. Only reset exits this state.
- mem_ack_I is ignored outside WRITE.
- A legal accept clears err_code to 0.
- Reset asserted while in WRITE drops the pending word. The address returns to START_ADDR.
- Encoding by format:
  - R (opcode 0110011): funct7 = 0100000 for sub/sra, 0000000 otherwise. funct3: add/sub 000, sll 001, slt 010, xor 100, srl/sra 101, or 110, and 111.
  - I-ALU (0010011): addi 000, slti 010, xori 100, ori 110, andi 111; imm[11:0] in bits 31:20. Legal imm range is -2048..2047.
  - Shifts (0010011): slli 001, srli 101, srai 101. Bits 31:26 are 000000, or 010000 for srai. Bits 25:20 = shamt. Legal shamt is 0..63.
  - ld (0000011, funct3 011) and jalr (1100111, funct3 000): I-type, range -2048..2047.
  - sd (0100011, funct3 011): imm[11:5] in bits 31:25, imm[4:0] in bits 11:7. Range -2048..2047.
  - beq/bne (1100011, funct3 000/001): B-type. imm must be even, in the range -4096..4094.
  - jal (1101111): J-type. imm must be even, in the range -1048576..1048574.
- Register fields not used by a format are encoded as 0: rs2 for I-type, rd for S/B-type, rs1/rs2 for J-type.

Test Plan:
- Reset, then addi rd=1 rs1=0 imm=5 → mem_wen_O high 1 cycle after accept, mem_wdata_O=0x00500093, mem_addr_O=START_ADDR. After ack: mem_addr_O=START_ADDR+1, word_count=1.
- Back-to-back with immediate acks: add 3,1,2 → 0x002081B3; sub → 0x402081B3; srai rd=5 rs1=6 imm=3 → 0x40335293; sd rs1=1 rs2=2 imm=8 → 0x0020B423. Addresses increment by 1 per ack.
- beq rs1=1 rs2=2 imm=8 → 0x00208463. jal rd=1 imm=16 → 0x010000EF. Hold mem_ack_I low for 5 cycles: mem_wen_O, mem_addr_O and mem_wdata_O stay stable, and in_ready stays 0.
- Errors: instruction_type=0x000003 → err_o pulse, err_code=1, no write. addi imm=2048 → err_code=2. beq imm=7 → err_code=2. A following legal request clears err_code and writes at the unchanged address.
- DEPTH=2: two acked writes → full_o=1 and in_ready=0. A third in_valid is ignored.
- Assert rst_n low during WRITE → next cycle mem_wen_O=0, mem_addr_O=START_ADDR, word_count=0.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// RV64 instruction encoder: packs one decoded instruction per handshake into a
// 32-bit machine word and writes it to consecutive instruction-memory word addresses.
module rv_inst_encoder #(
  parameter logic [29:0] START_ADDR = 30'd0,
  parameter int          DEPTH      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] instruction_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [29:0] mem_addr_O,
  output logic [31:0] mem_wdata_O,
  output logic        mem_wen_O,
  input  logic        mem_ack_I,
  output logic        err_o,
  output logic [1:0]  err_code,
  output logic [15:0] word_count,
  output logic        full_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  localparam int T_JAL  = 22, T_JALR = 21, T_BEQ  = 20, T_BNE  = 19, T_LD   = 18, T_SD  = 17;
  localparam int T_ADDI = 16, T_SLTI = 15, T_XORI = 14, T_ORI  = 13, T_ANDI = 12;
  localparam int T_SLLI = 11, T_SRLI = 10, T_SRAI = 9;
  localparam int T_ADD  = 8,  T_SUB  = 7,  T_SLL  = 6,  T_SLT  = 5,  T_XOR  = 4;
  localparam int T_SRL  = 3,  T_SRA  = 2,  T_OR   = 1,  T_AND  = 0;

  logic [1:0]  state_reg;
  logic [29:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        wen_reg;
  logic        err_reg;
  logic [1:0]  err_code_reg;
  logic [15:0] count_reg;
  logic        full_reg;

  logic [31:0] enc_next;
  logic        imm_ok;
  logic        type_ok;
  logic [22:0] seen_upto;
  logic [22:0] dup;
  logic signed [31:0] imm_s;

  assign imm_s = imm;

  // One-hot check: a bit is a duplicate if any lower bit is already set.
  genvar gi;
  generate
    for (gi = 0; gi < 23; gi++) begin : g_onehot
      if (gi == 0) begin : g_first
        assign seen_upto[gi] = instruction_type[gi];
        assign dup[gi]       = 1'b0;
      end else begin : g_rest
        assign seen_upto[gi] = seen_upto[gi-1] | instruction_type[gi];
        assign dup[gi]       = seen_upto[gi-1] & instruction_type[gi];
      end
    end
  endgenerate

  assign type_ok = seen_upto[22] & ~(|dup);

  always_comb begin
    logic imm12_ok;
    logic even;
    enc_next = 32'd0;
    imm_ok   = 1'b0;
    imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    even     = ~imm[0];
    if (instruction_type[T_JAL]) begin
      imm_ok   = even && (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
      enc_next = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    end else if (instruction_type[T_JALR]) begin
      imm_ok   = imm12_ok;
      enc_next = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
    end else if (instruction_type[T_BEQ] || instruction_type[T_BNE]) begin
      imm_ok   = even && (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
      enc_next = {imm[12], imm[10:5], rs2, rs1, {2'b00, instruction_type[T_BNE]},
                  imm[4:1], imm[11], 7'b1100011};
    end else if (instruction_type[T_LD]) begin
      imm_ok   = imm12_ok;
      enc_next = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
    end else if (instruction_type[T_SD]) begin
      imm_ok   = imm12_ok;
      enc_next = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    end else if (instruction_type[T_ADDI] || instruction_type[T_SLTI] || instruction_type[T_XORI] ||
                 instruction_type[T_ORI]  || instruction_type[T_ANDI]) begin
      imm_ok = imm12_ok;
      if (instruction_type[T_ADDI])      enc_next = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      else if (instruction_type[T_SLTI]) enc_next = {imm[11:0], rs1, 3'b010, rd, 7'b0010011};
      else if (instruction_type[T_XORI]) enc_next = {imm[11:0], rs1, 3'b100, rd, 7'b0010011};
      else if (instruction_type[T_ORI])  enc_next = {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
      else                               enc_next = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
    end else if (instruction_type[T_SLLI] || instruction_type[T_SRLI] || instruction_type[T_SRAI]) begin
      // RV64 shamt is 6 bits; funct6 distinguishes srai from srli.
      imm_ok = (imm_s >= 32'sd0) && (imm_s <= 32'sd63);
      if (instruction_type[T_SLLI])      enc_next = {6'b000000, imm[5:0], rs1, 3'b001, rd, 7'b0010011};
      else if (instruction_type[T_SRLI]) enc_next = {6'b000000, imm[5:0], rs1, 3'b101, rd, 7'b0010011};
      else                               enc_next = {6'b010000, imm[5:0], rs1, 3'b101, rd, 7'b0010011};
    end else begin
      imm_ok = 1'b1;
      if (instruction_type[T_ADD])      enc_next = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      else if (instruction_type[T_SUB]) enc_next = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      else if (instruction_type[T_SLL]) enc_next = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
      else if (instruction_type[T_SLT]) enc_next = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
      else if (instruction_type[T_XOR]) enc_next = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      else if (instruction_type[T_SRL]) enc_next = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
      else if (instruction_type[T_SRA]) enc_next = {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0110011};
      else if (instruction_type[T_OR])  enc_next = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      else                              enc_next = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
    end
  end

  assign in_ready = (state_reg == ST_IDLE) && !full_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= START_ADDR;
      wdata_reg    <= 32'd0;
      wen_reg      <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'd0;
      count_reg    <= 16'd0;
      full_reg     <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (!type_ok) begin
              err_reg      <= 1'b1;
              err_code_reg <= 2'd1;
            end else if (!imm_ok) begin
              err_reg      <= 1'b1;
              err_code_reg <= 2'd2;
            end else begin
              err_code_reg <= 2'd0;
              wdata_reg    <= enc_next;
              wen_reg      <= 1'b1;
              state_reg    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack_I) begin
            wen_reg   <= 1'b0;
            addr_reg  <= addr_reg + 30'd1;
            count_reg <= count_reg + 16'd1;
            if (count_reg + 16'd1 == DEPTH_W) begin
              state_reg <= ST_FULL;
              full_reg  <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_O  = addr_reg;
  assign mem_wdata_O = wdata_reg;
  assign mem_wen_O   = wen_reg;
  assign err_o       = err_reg;
  assign err_code    = err_code_reg;
  assign word_count  = count_reg;
  assign full_o      = full_reg;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: stimulus queues expected writes/errors,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rv_inst_encoder;

  localparam logic [29:0] START = 30'h100;

  localparam logic [22:0] T_JAL  = 23'h1 << 22, T_JALR = 23'h1 << 21, T_BEQ  = 23'h1 << 20;
  localparam logic [22:0] T_BNE  = 23'h1 << 19, T_LD   = 23'h1 << 18, T_SD   = 23'h1 << 17;
  localparam logic [22:0] T_ADDI = 23'h1 << 16, T_ANDI = 23'h1 << 12, T_SLLI = 23'h1 << 11;
  localparam logic [22:0] T_SRAI = 23'h1 << 9,  T_ADD  = 23'h1 << 8,  T_SUB  = 23'h1 << 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] instruction_type = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic [29:0] mem_addr_O;
  logic [31:0] mem_wdata_O;
  logic        mem_wen_O;
  logic        mem_ack_I = 1'b0;
  logic        err_o;
  logic [1:0]  err_code;
  logic [15:0] word_count;
  logic        full_o;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [29:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic        mem_wen2;
  logic        mem_ack2 = 1'b0;
  logic        err2;
  logic [1:0]  err_code2;
  logic [15:0] word_count2;
  logic        full2;

  rv_inst_encoder #(.START_ADDR(START), .DEPTH(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_addr_O(mem_addr_O), .mem_wdata_O(mem_wdata_O), .mem_wen_O(mem_wen_O),
    .mem_ack_I(mem_ack_I), .err_o(err_o), .err_code(err_code),
    .word_count(word_count), .full_o(full_o)
  );

  rv_inst_encoder #(.START_ADDR(30'd0), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .instruction_type(instruction_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_addr_O(mem_addr2), .mem_wdata_O(mem_wdata2), .mem_wen_O(mem_wen2),
    .mem_ack_I(mem_ack2), .err_o(err2), .err_code(err_code2),
    .word_count(word_count2), .full_o(full2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [61:0] wr_q[$];
  logic [1:0]  err_q[$];
  logic [29:0] exp_addr;
  int          exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes/errors as the DUT presents them.
  logic        prev_wen = 1'b0, prev_ack = 1'b0;
  logic [29:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen_O) check("ready_low_in_write", 32'(in_ready), 32'd0);
      if (mem_wen_O && prev_wen && !prev_ack) begin
        check("hold_addr", 32'(mem_addr_O), 32'(prev_addr));
        check("hold_data", mem_wdata_O, prev_data);
      end
      if (mem_wen_O && mem_ack_I) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(mem_wen_O), 32'd0);
        end else begin
          logic [61:0] e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr_O), 32'(e[61:32]));
          check("wr_data", mem_wdata_O, e[31:0]);
          $display("write addr=0x%08h data=0x%08h", mem_addr_O, mem_wdata_O);
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) begin
          check("unexpected_err", 32'(err_o), 32'd0);
        end else begin
          logic [1:0] ec;
          ec = err_q.pop_front();
          check("err_code_mon", 32'(err_code), 32'(ec));
          $display("error code=%0d", err_code);
        end
      end
    end
    prev_wen  <= mem_wen_O;
    prev_ack  <= mem_ack_I;
    prev_addr <= mem_addr_O;
    prev_data <= mem_wdata_O;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [22:0] t, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [1:0] exp_err, input logic [31:0] exp_word, input int ack_delay);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    instruction_type = t; rd = d; rs1 = s1; rs2 = s2; imm = im;
    if (exp_err == 2'd0) wr_q.push_back({exp_addr, exp_word});
    else                 err_q.push_back(exp_err);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (exp_err == 2'd0) begin
      check("wen_latency", 32'(mem_wen_O), 32'd1);
      repeat (ack_delay) step();
      mem_ack_I = 1'b1;
      step();
      mem_ack_I = 1'b0;
      exp_addr++;
      exp_count++;
      check("addr_after_ack", 32'(mem_addr_O), 32'(exp_addr));
      check("count_after_ack", 32'(word_count), 32'(exp_count));
      check("wen_after_ack", 32'(mem_wen_O), 32'd0);
    end else begin
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_code", 32'(err_code), 32'(exp_err));
      check("no_write", 32'(mem_wen_O), 32'd0);
      check("addr_unchanged", 32'(mem_addr_O), 32'(exp_addr));
      step();
      check("err_pulse_end", 32'(err_o), 32'd0);
    end
  endtask

  initial begin
    exp_addr  = START;
    exp_count = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_addr", 32'(mem_addr_O), 32'(START));
    check("rst_wdata", mem_wdata_O, 32'd0);
    check("rst_wen", 32'(mem_wen_O), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,  2'd0, 32'h00500093, 2);
    send(T_ADD,  5'd3, 5'd1, 5'd2, 32'd0,  2'd0, 32'h002081B3, 0);
    send(T_SUB,  5'd3, 5'd1, 5'd2, 32'd0,  2'd0, 32'h402081B3, 0);
    send(T_SRAI, 5'd5, 5'd6, 5'd0, 32'd3,  2'd0, 32'h40335293, 0);
    send(T_SD,   5'd0, 5'd1, 5'd2, 32'd8,  2'd0, 32'h0020B423, 0);
    send(T_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,  2'd0, 32'h00208463, 0);
    send(T_JAL,  5'd1, 5'd0, 5'd0, 32'd16, 2'd0, 32'h010000EF, 5);
    send(T_LD,   5'd2, 5'd3, 5'd0, -32'sd8, 2'd0, 32'hFF81B103, 1);
    send(T_BNE,  5'd0, 5'd5, 5'd6, -32'sd4, 2'd0, 32'hFE629EE3, 0);
    send(T_SLLI, 5'd7, 5'd7, 5'd0, 32'd63, 2'd0, 32'h03F39393, 0);
    send(T_JALR, 5'd0, 5'd1, 5'd0, 32'd0,  2'd0, 32'h00008067, 0);
    send(T_JAL,  5'd0, 5'd0, 5'd0, -32'sd1048576, 2'd0, 32'h8000006F, 0);

    send(23'h000003, 5'd1, 5'd1, 5'd1, 32'd0,    2'd1, 32'd0, 0);
    send(23'h000000, 5'd1, 5'd1, 5'd1, 32'd0,    2'd1, 32'd0, 0);
    send(T_ADDI,     5'd1, 5'd0, 5'd0, 32'd2048, 2'd2, 32'd0, 0);
    send(T_BEQ,      5'd0, 5'd1, 5'd2, 32'd7,    2'd2, 32'd0, 0);
    send(T_SLLI,     5'd1, 5'd1, 5'd0, 32'd64,   2'd2, 32'd0, 0);
    send(T_ANDI, 5'd4, 5'd4, 5'd0, 32'hFFFFFFFF, 2'd0, 32'hFFF27213, 0);
    check("err_code_cleared", 32'(err_code), 32'd0);

    // Reset while a write is pending: the word is dropped.
    instruction_type = T_ADDI; rd = 5'd1; rs1 = 5'd0; imm = 32'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pending_wen", 32'(mem_wen_O), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_in_write_wen", 32'(mem_wen_O), 32'd0);
    check("rst_in_write_addr", 32'(mem_addr_O), 32'(START));
    check("rst_in_write_count", 32'(word_count), 32'd0);
    $display("reset during write: wen=%0d addr=0x%08h count=%0d", mem_wen_O, mem_addr_O, word_count);

    // DEPTH=2 instance fills after two acked writes.
    instruction_type = T_ADD; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
    for (int i = 0; i < 2; i++) begin
      check("d2_ready", 32'(in_ready2), 32'd1);
      in_valid2 = 1'b1;
      step();
      in_valid2 = 1'b0;
      check("d2_wen", 32'(mem_wen2), 32'd1);
      check("d2_addr", 32'(mem_addr2), i);
      check("d2_data", mem_wdata2, 32'h002081B3);
      mem_ack2 = 1'b1;
      step();
      mem_ack2 = 1'b0;
      $display("d2 write %0d count=%0d full=%0d", i, word_count2, full2);
    end
    check("d2_full", 32'(full2), 32'd1);
    check("d2_ready_full", 32'(in_ready2), 32'd0);
    check("d2_count", 32'(word_count2), 32'd2);
    in_valid2 = 1'b1;
    repeat (3) step();
    in_valid2 = 1'b0;
    check("d2_ignored_wen", 32'(mem_wen2), 32'd0);
    check("d2_ignored_count", 32'(word_count2), 32'd2);
    check("d2_ignored_addr", 32'(mem_addr2), 32'd2);

    step();
    check("wr_q_empty", wr_q.size(), 32'd0);
    check("err_q_empty", err_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
